// File: rtl/dcfifo_pkg.sv
// Shared definitions for the dcfifo test-clock meter: default sizing and gate FSM encoding.
package dcfifo_pkg;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int CNT_W_DEF    = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } meter_state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by an edge flop; emits a one-cycle pulse per rising edge
// of an asynchronous input.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= async_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/dcfifo_clk_meter.sv
// Frequency / period meter for a slow asynchronous clock, with loss-of-clock detection.
// meas_valid is a one-cycle strobe with no back-pressure: freq_hz is valid in that cycle and holds until the next strobe.
module dcfifo_clk_meter
  import dcfifo_pkg::*;
#(
  parameter int CLK_FREQ       = CLK_FREQ_DEF,
  parameter int GATE_CYCLES    = CLK_FREQ,
  parameter int TIMEOUT_CYCLES = CLK_FREQ * 2,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clk_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] freq_hz,
  output logic [CNT_W-1:0] period_cyc,
  output logic             meas_valid,
  output logic             clk_lost,
  output meter_state_e     fsm_state
);

  if (GATE_CYCLES < 2 || longint'(GATE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_gate
    $error("GATE_CYCLES must be >= 2 and < 2**CNT_W");
  end
  if (TIMEOUT_CYCLES < 2 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 2 and < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic rise;

  sync_edge_det u_sync (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .async_i (clk_in),
    .rise_o  (rise)
  );

  meter_state_e     state_q;
  logic [CNT_W-1:0] gate_cnt_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic [CNT_W-1:0] freq_q;
  logic             valid_q;
  logic [CNT_W-1:0] edge_inc;

  // Saturating edge count including the current cycle's rise, so a rise on the last gate cycle lands in this window.
  assign edge_inc = (rise && edge_cnt_q != '1) ? edge_cnt_q + ONE : edge_cnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          gate_cnt_q <= '0;
          edge_cnt_q <= '0;
          if (meas_en) state_q <= ST_GATE;
        end
        ST_GATE: begin
          if (!meas_en) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
          end else if (gate_cnt_q == GATE_LAST) begin
            freq_q     <= edge_inc;
            valid_q    <= 1'b1;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
          end else begin
            gate_cnt_q <= gate_cnt_q + ONE;
            edge_cnt_q <= edge_inc;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             seen_q, seen_d;
  logic             lost_q, lost_d;
  logic [CNT_W-1:0] per_inc;

  assign per_inc = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + ONE;

  // A rise takes priority over the timeout; the first rise after reset or loss only arms the path.
  always_comb begin
    per_cnt_d = per_inc;
    period_d  = period_q;
    seen_d    = seen_q;
    lost_d    = lost_q;
    if (rise) begin
      if (seen_q) period_d = per_inc;
      per_cnt_d = '0;
      seen_d    = 1'b1;
      lost_d    = 1'b0;
    end else if (per_cnt_q == TO_LAST) begin
      lost_d   = 1'b1;
      period_d = '0;
      seen_d   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      per_cnt_q <= '0;
      period_q  <= '0;
      seen_q    <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      per_cnt_q <= per_cnt_d;
      period_q  <= period_d;
      seen_q    <= seen_d;
      lost_q    <= lost_d;
    end
  end

  assign freq_hz    = freq_q;
  assign period_cyc = period_q;
  assign meas_valid = valid_q;
  assign clk_lost   = lost_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_dcfifo_clk_meter.sv
// Directed bench for dcfifo_clk_meter with small gate/timeout windows; clk_in is driven on sys_clk negedges.
module tb_dcfifo_clk_meter;
  import dcfifo_pkg::*;

  logic         sys_clk;
  logic         sys_rst;
  logic         clk_in;
  logic         meas_en;
  logic [31:0]  freq_hz;
  logic [31:0]  period_cyc;
  logic         meas_valid;
  logic         clk_lost;
  meter_state_e fsm_state;

  dcfifo_clk_meter #(
    .CLK_FREQ       (1000),
    .GATE_CYCLES    (1000),
    .TIMEOUT_CYCLES (500),
    .CNT_W          (32)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .clk_in     (clk_in),
    .meas_en    (meas_en),
    .freq_hz    (freq_hz),
    .period_cyc (period_cyc),
    .meas_valid (meas_valid),
    .clk_lost   (clk_lost),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int          cyc;
  int          n_cmp;
  int          n_err;
  int          ph;
  int          gen_per;
  int          last_rise;
  bit          gen_on;
  logic [31:0] exp_q[$];

  // driver tasks
  task automatic set_clk(input logic v);
    if (v && !clk_in) begin
      last_rise = cyc;
      exp_q.push_back(32'(cyc));
    end
    clk_in = v;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (gen_on) begin
      set_clk(ph < gen_per / 2);
      ph = (ph + 1 == gen_per) ? 0 : ph + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (meas_valid !== 1'b1 && waited < max);
    n_cmp++;
    assert (meas_valid === 1'b1) else begin
      n_err++;
      $error("FAIL wait_valid: observed no meas_valid expected one within %0d cycles", max);
    end
  endtask

  initial begin
    int w;
    int nv;
    int cnt;
    int r;
    cyc = 0; n_cmp = 0; n_err = 0; ph = 0; gen_per = 200; last_rise = 0; gen_on = 0;
    sys_rst = 1'b1; clk_in = 1'b0; meas_en = 1'b0;

    // reset state
    #2;
    check("rst_freq", freq_hz, 32'd0);
    check("rst_period", period_cyc, 32'd0);
    check("rst_valid", meas_valid, 1'b0);
    check("rst_lost", clk_lost, 1'b0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    tick(); tick();
    sys_rst = 1'b0;

    // 1: 200-cycle clk_in, back-to-back windows
    gen_per = 200; ph = 0; gen_on = 1; meas_en = 1'b1;
    wait_valid(1200, w);
    check("t1_first_lat", w, 32'd1001);
    check("t1_first_freq", freq_hz, 32'd5);
    for (int i = 0; i < 2; i++) begin
      wait_valid(1200, w);
      check("t1_spacing", w, 32'd1000);
      check("t1_freq", freq_hz, 32'd5);
      check("t1_period", period_cyc, 32'd200);
    end
    tick();
    check("t1_valid_width", meas_valid, 1'b0);

    // 2: abort at gate_cnt=600, re-enable 50 cycles later
    nv = 0;
    repeat (599) begin
      tick();
      if (meas_valid) nv++;
    end
    meas_en = 1'b0;
    tick();
    check("t2_idle", 32'(fsm_state), 32'(ST_IDLE));
    repeat (49) begin
      tick();
      if (meas_valid) nv++;
    end
    check("t2_no_valid", nv, 32'd0);
    check("t2_freq_hold", freq_hz, 32'd5);
    meas_en = 1'b1;
    wait_valid(1200, w);
    check("t2_reenable_lat", w, 32'd1001);
    check("t2_freq", freq_hz, 32'd5);

    // 3: stop clk_in, timeout, restart
    w = 0;
    do begin
      tick();
      w++;
    end while (last_rise != cyc && w < 300);
    check("t3_found_rise", 32'(last_rise), 32'(cyc));
    check("t3_period_pre", period_cyc, 32'd200);
    repeat (100) tick();
    gen_on = 0;
    set_clk(1'b0);
    w = 0;
    do begin
      tick();
      w++;
    end while (clk_lost !== 1'b1 && w < 1000);
    check("t3_lost_delay", 32'(cyc - last_rise), 32'd503);
    check("t3_lost_period", period_cyc, 32'd0);
    gen_per = 200; ph = 0; gen_on = 1;
    tick();
    r = cyc;
    tick(); tick();
    check("t3_lost_hold", clk_lost, 1'b1);
    tick();
    check("t3_lost_clear", clk_lost, 1'b0);
    check("t3_first_rise_period", period_cyc, 32'd0);
    repeat (199) tick();
    check("t3_before_second", period_cyc, 32'd0);
    tick();
    check("t3_second_rise_period", period_cyc, 32'd200);
    check("t3_restart_cycle", 32'(cyc - r), 32'd203);

    // 4: single rise on gate_cnt=999
    gen_on = 0;
    set_clk(1'b0);
    wait_valid(1100, w);
    wait_valid(1100, w);
    check("t4_quiet_freq", freq_hz, 32'd0);
    repeat (997) tick();
    set_clk(1'b1);
    repeat (3) tick();
    check("t4_valid_edge", meas_valid, 1'b1);
    check("t4_last_cycle_freq", freq_hz, 32'd1);
    set_clk(1'b0);
    wait_valid(1100, w);
    check("t4_next_spacing", w, 32'd1000);
    check("t4_next_freq", freq_hz, 32'd0);

    // 5: asynchronous reset mid-window
    gen_per = 200; ph = 0; gen_on = 1;
    wait_valid(1200, w);
    wait_valid(1200, w);
    check("t5_pre_freq", freq_hz, 32'd5);
    repeat (300) tick();
    check("t5_pre_period", period_cyc, 32'd200);
    #3;
    sys_rst = 1'b1;
    gen_on = 0;
    set_clk(1'b0);
    #1;
    check("t5_rst_freq", freq_hz, 32'd0);
    check("t5_rst_period", period_cyc, 32'd0);
    check("t5_rst_valid", meas_valid, 1'b0);
    check("t5_rst_lost", clk_lost, 1'b0);
    check("t5_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    tick(); tick();
    check("t5_held_valid", meas_valid, 1'b0);
    sys_rst = 1'b0;
    ph = 1; gen_on = 1;
    set_clk(1'b1);
    repeat (3) tick();
    check("t5_arm_only", period_cyc, 32'd0);
    wait_valid(1200, w);
    check("t5_restart_lat", w, 32'd998);
    check("t5_restart_freq", freq_hz, 32'd5);
    check("t5_restart_period", period_cyc, 32'd200);

    // 6: random-phase clk_in at 1/7 sys_clk, scoreboarded over 10 windows
    gen_per = 7;
    ph = int'($urandom_range(0, 6));
    wait_valid(1100, w);
    while (exp_q.size() > 0 && int'(exp_q[0]) + 2 <= cyc - 1) void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      wait_valid(1100, w);
      check("t6_spacing", w, 32'd1000);
      cnt = 0;
      while (exp_q.size() > 0 && int'(exp_q[0]) + 2 <= cyc - 1) begin
        void'(exp_q.pop_front());
        cnt++;
      end
      check("t6_scoreboard", freq_hz, 32'(cnt));
      n_cmp++;
      assert (freq_hz >= 32'd142 && freq_hz <= 32'd144) else begin
        n_err++;
        $error("FAIL t6_range: observed %0d expected 142..144", freq_hz);
      end
    end
    check("t6_period", period_cyc, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
